// File: rtl/multi_pattern_seq_detector.sv
// Serial bit-stream detector: matches the last PAT_W sampled bits against NUM_PAT
// programmable patterns, paced by an internal clock-enable tick divider.
module multi_pattern_seq_detector #(
    parameter int PAT_W    = 4,
    parameter int NUM_PAT  = 3,
    parameter int TICK_DIV = 50_000_000,
    parameter int CNT_W    = 16,
    localparam int ID_W    = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_bit,
    input  logic [NUM_PAT*PAT_W-1:0]   pat_cfg,
    input  logic [NUM_PAT-1:0]         pat_en,
    input  logic                       overlap,
    input  logic                       clr_cnt,
    output logic                       tick,
    output logic [NUM_PAT-1:0]         match_vec,
    output logic                       y,
    output logic                       match_stb,
    output logic [ID_W-1:0]            last_id,
    output logic [NUM_PAT*CNT_W-1:0]   match_cnt
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FILL_W = $clog2(PAT_W);

    typedef enum logic {
        FILLING = 1'b0,
        ARMED   = 1'b1
    } fill_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic [DIV_W-1:0]  div_cnt;
    logic [PAT_W-2:0]  hist, hist_next;
    logic [FILL_W-1:0] fill, fill_next;
    fill_state_t       state, state_next;
    logic [PAT_W-1:0]  window;
    logic [NUM_PAT-1:0] hit;
    logic [ID_W-1:0]   first_id;
    logic [CNT_W-1:0]  cnt [NUM_PAT];

    // Tick divider: tick is registered and asserted on the wrap of the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            tick    <= 1'b0;
        end
    end

    assign window = {hist, in_bit};

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            hit[i] = pat_en[i] && (state == ARMED) &&
                     (window == pat_cfg[i*PAT_W +: PAT_W]);
        end
    end

    always_comb begin
        first_id = '0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                first_id = ID_W'(i);
            end
        end
    end

    // Fill tracker and history register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FILLING;
            fill  <= '0;
            hist  <= '0;
        end else begin
            state <= state_next;
            fill  <= fill_next;
            hist  <= hist_next;
        end
    end

    // Non-overlapping mode discards all history on a match so the next one needs fresh bits
    always_comb begin
        state_next = state;
        fill_next  = fill;
        hist_next  = hist;
        if (tick) begin
            if (!overlap && (|hit)) begin
                state_next = FILLING;
                fill_next  = '0;
                hist_next  = '0;
            end else begin
                hist_next = window[PAT_W-2:0];
                if (fill != FILL_W'(PAT_W - 1)) begin
                    fill_next = fill + 1'b1;
                end
                state_next = (fill_next == FILL_W'(PAT_W - 1)) ? ARMED : FILLING;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_vec <= '0;
            y         <= 1'b0;
            match_stb <= 1'b0;
            last_id   <= '0;
        end else begin
            match_stb <= 1'b0;
            if (tick) begin
                match_vec <= hit;
                y         <= |hit;
                match_stb <= |hit;
                if (|hit) begin
                    last_id <= first_id;
                end
            end
        end
    end

    // Clear takes priority over a coincident increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PAT; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PAT; i++) begin
                if (clr_cnt) begin
                    cnt[i] <= '0;
                end else if (tick && hit[i]) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < NUM_PAT; i++) begin
            match_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// Bench for multi_pattern_seq_detector: directed scenarios plus random streams
// checked against a queue-based reference model of the sampled bit history.
module tb_multi_pattern_seq_detector;

    localparam int PAT_W    = 4;
    localparam int NUM_PAT  = 3;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 2;
    localparam int ID_W     = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      in_bit;
    logic [NUM_PAT*PAT_W-1:0]  pat_cfg;
    logic [NUM_PAT-1:0]        pat_en;
    logic                      overlap;
    logic                      clr_cnt;
    logic                      tick;
    logic [NUM_PAT-1:0]        match_vec;
    logic                      y;
    logic                      match_stb;
    logic [ID_W-1:0]           last_id;
    logic [NUM_PAT*CNT_W-1:0]  match_cnt;

    int compared   = 0;
    int mismatched = 0;

    bit                 bits_q[$];
    int                 cnt_m [NUM_PAT];
    logic [NUM_PAT-1:0] vec_m;
    int                 id_m;

    multi_pattern_seq_detector #(
        .PAT_W(PAT_W), .NUM_PAT(NUM_PAT), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .in_bit(in_bit), .pat_cfg(pat_cfg),
        .pat_en(pat_en), .overlap(overlap), .clr_cnt(clr_cnt), .tick(tick),
        .match_vec(match_vec), .y(y), .match_stb(match_stb), .last_id(last_id),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        bits_q.delete();
        for (int i = 0; i < NUM_PAT; i++) cnt_m[i] = 0;
        vec_m = '0;
        id_m  = 0;
    endfunction

    // A pattern can only match once PAT_W bits have been sampled since the last clear
    function automatic logic [NUM_PAT-1:0] model_hits();
        logic [NUM_PAT-1:0] h = '0;
        int v = 0;
        int n = bits_q.size();
        if (n >= PAT_W) begin
            for (int k = n - PAT_W; k < n; k++) v = v * 2 + int'(bits_q[k]);
            for (int i = 0; i < NUM_PAT; i++)
                if (pat_en[i] && v == int'(pat_cfg[i*PAT_W +: PAT_W])) h[i] = 1'b1;
        end
        return h;
    endfunction

    function automatic logic [NUM_PAT*CNT_W-1:0] model_cnt();
        logic [NUM_PAT*CNT_W-1:0] c = '0;
        for (int i = 0; i < NUM_PAT; i++) c[i*CNT_W +: CNT_W] = CNT_W'(cnt_m[i]);
        return c;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic clr);
        int guard = 0;
        logic [NUM_PAT-1:0] h;
        @(negedge clk);
        while (tick !== 1'b1 && guard < 3 * TICK_DIV) begin
            @(negedge clk);
            guard++;
        end
        compared++;
        if (tick !== 1'b1) begin
            mismatched++;
            $display("FAIL tick_wait: tick=%b required 1 within %0d clks", tick, 3 * TICK_DIV);
        end
        in_bit  = b;
        clr_cnt = clr;
        bits_q.push_back(b);
        if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
        h = model_hits();
        for (int i = 0; i < NUM_PAT; i++) begin
            if (clr) cnt_m[i] = 0;
            else if (h[i] && cnt_m[i] < CNT_MAX) cnt_m[i]++;
        end
        vec_m = h;
        for (int i = NUM_PAT - 1; i >= 0; i--) if (h[i]) id_m = i;
        if (!overlap && (|h)) bits_q.delete();

        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        compared++;
        if (match_vec !== vec_m) begin
            mismatched++;
            $display("FAIL match_vec: got %b required %b", match_vec, vec_m);
        end
        compared++;
        if (y !== (|vec_m)) begin
            mismatched++;
            $display("FAIL y: got %b required %b", y, |vec_m);
        end
        compared++;
        if (match_stb !== (|h)) begin
            mismatched++;
            $display("FAIL match_stb: got %b required %b", match_stb, |h);
        end
        compared++;
        if (last_id !== ID_W'(id_m)) begin
            mismatched++;
            $display("FAIL last_id: got %0d required %0d", last_id, id_m);
        end
        compared++;
        if (match_cnt !== model_cnt()) begin
            mismatched++;
            $display("FAIL match_cnt: got %h required %h", match_cnt, model_cnt());
        end

        @(posedge clk);
        #1;
        compared++;
        if (match_stb !== 1'b0 || tick !== 1'b0 || match_vec !== vec_m) begin
            mismatched++;
            $display("FAIL hold: stb=%b tick=%b vec=%b required stb=0 tick=0 vec=%b",
                     match_stb, tick, match_vec, vec_m);
        end
    endtask

    task automatic send_word(input logic [PAT_W-1:0] w);
        for (int k = PAT_W - 1; k >= 0; k--) send_bit(w[k], 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({tick, match_vec, y, match_stb, last_id, match_cnt} !== '0) begin
            mismatched++;
            $display("FAIL reset_state: got %b required all zero",
                     {tick, match_vec, y, match_stb, last_id, match_cnt});
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3 * TICK_DIV; k++) begin
            @(posedge clk);
            #1;
            compared++;
            if (tick !== ((k % TICK_DIV) == 0)) begin
                mismatched++;
                $display("FAIL tick_period: clk %0d tick=%b required %b", k, tick, (k % TICK_DIV) == 0);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_word(4'b1100);
        compared++;
        if (match_vec !== 3'b001 || last_id !== 2'd0 || match_cnt[0 +: CNT_W] !== 2'd1) begin
            mismatched++;
            $display("FAIL basic: vec=%b id=%0d cnt0=%0d required 001/0/1",
                     match_vec, last_id, match_cnt[0 +: CNT_W]);
        end
    endtask

    task automatic test_overlap();
        do_reset();
        send_bit(1, 0); send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
        compared++;
        if (match_vec !== 3'b010) begin
            mismatched++;
            $display("FAIL overlap_t4: vec=%b required 010", match_vec);
        end
        send_bit(0, 0);
        compared++;
        if (match_vec !== 3'b000) begin
            mismatched++;
            $display("FAIL overlap_t5: vec=%b required 000", match_vec);
        end
        send_bit(1, 0);
        compared++;
        if (match_vec !== 3'b100 || last_id !== 2'd2 || match_cnt !== 6'b01_01_00) begin
            mismatched++;
            $display("FAIL overlap_t6: vec=%b id=%0d cnt=%b required 100/2/010100",
                     match_vec, last_id, match_cnt);
        end
    endtask

    task automatic test_nonoverlap();
        logic [1:0] want;
        for (int m = 1; m >= 0; m--) begin
            overlap = logic'(m);
            do_reset();
            send_bit(1, 0); send_bit(0, 0); send_bit(1, 0);
            send_bit(0, 0); send_bit(1, 0); send_bit(0, 0);
            want = (m == 1) ? 2'd2 : 2'd1;
            compared++;
            if (match_cnt[CNT_W +: CNT_W] !== want) begin
                mismatched++;
                $display("FAIL overlap_mode%0d: cnt1=%0d required %0d", m, match_cnt[CNT_W +: CNT_W], want);
            end
        end
        overlap = 1'b1;
    endtask

    task automatic test_saturation();
        overlap = 1'b0;
        do_reset();
        repeat (5) send_word(4'b1100);
        compared++;
        if (match_cnt[0 +: CNT_W] !== 2'd3) begin
            mismatched++;
            $display("FAIL saturate: cnt0=%0d required 3", match_cnt[0 +: CNT_W]);
        end
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0); send_bit(0, 1);
        compared++;
        if (match_cnt[0 +: CNT_W] !== 2'd0 || match_vec !== 3'b001) begin
            mismatched++;
            $display("FAIL clr_wins: cnt0=%0d vec=%b required 0/001", match_cnt[0 +: CNT_W], match_vec);
        end
        overlap = 1'b1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(4'b1100);
        send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if ({tick, match_vec, y, match_stb, last_id, match_cnt} !== '0) begin
            mismatched++;
            $display("FAIL async_reset: got %b required all zero",
                     {tick, match_vec, y, match_stb, last_id, match_cnt});
        end
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        send_bit(0, 0);
        compared++;
        if (match_vec !== 3'b000 || y !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_nomatch: vec=%b y=%b required 000/0", match_vec, y);
        end
        send_word(4'b1100);
        compared++;
        if (match_vec !== 3'b001 || match_cnt !== 6'b00_00_01) begin
            mismatched++;
            $display("FAIL post_reset_match: vec=%b cnt=%b required 001/000001", match_vec, match_cnt);
        end
    endtask

    task automatic test_simultaneous();
        pat_cfg = {4'b1100, 4'b1010, 4'b1100};
        do_reset();
        send_word(4'b1100);
        compared++;
        if (match_vec !== 3'b101 || last_id !== 2'd0 || match_cnt !== 6'b01_00_01) begin
            mismatched++;
            $display("FAIL simultaneous: vec=%b id=%0d cnt=%b required 101/0/010001",
                     match_vec, last_id, match_cnt);
        end
        pat_en = 3'b100;
        send_word(4'b1100);
        compared++;
        if (match_vec !== 3'b100 || last_id !== 2'd2 || match_cnt !== 6'b10_00_01) begin
            mismatched++;
            $display("FAIL masked: vec=%b id=%0d cnt=%b required 100/2/100001",
                     match_vec, last_id, match_cnt);
        end
        pat_en  = 3'b111;
        pat_cfg = {4'b1001, 4'b1010, 4'b1100};
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) pat_cfg = NUM_PAT*PAT_W'($urandom);
            if ($urandom_range(0, 15) == 0) pat_en = NUM_PAT'($urandom);
            if ($urandom_range(0, 31) == 0) overlap = ~overlap;
            send_bit(logic'($urandom_range(0, 1)), $urandom_range(0, 19) == 0);
        end
        pat_en  = 3'b111;
        overlap = 1'b1;
        pat_cfg = {4'b1001, 4'b1010, 4'b1100};
    endtask

    initial begin
        reset   = 1'b1;
        in_bit  = 1'b0;
        pat_cfg = {4'b1001, 4'b1010, 4'b1100};
        pat_en  = 3'b111;
        overlap = 1'b1;
        clr_cnt = 1'b0;
        model_clear();
        test_reset();
        test_basic();
        test_overlap();
        test_nonoverlap();
        test_saturation();
        test_mid_reset();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
